// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and single-outstanding instruction fetch
//
// Purpose: holds the architectural PC, fetches one instruction at a time from
// instruction memory over req/ack, presents it to decode over valid/ready, loads
// the externally computed next PC on acceptance, and parks in an error state if
// memory never answers.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   next_pc                next-PC result, sampled only on the decode handshake
//   curr_pc                current PC, fed to the next-PC logic
//   imem_req / imem_addr   fetch request and address (address == curr_pc)
//   imem_ack / imem_data   memory response, honoured only while imem_req=1
//   instr / instr_pc       fetched instruction and its PC
//   instr_valid / instr_ready  decode handshake
//   fetch_err              sticky memory-timeout flag, cleared only by reset

module instr_fetch_unit #(
   parameter int                     PC_WIDTH    = 8,
   parameter int                     INSTR_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
   parameter int                     TIMEOUT     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PC_WIDTH-1:0]    next_pc,
   output logic [PC_WIDTH-1:0]    curr_pc,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic                   fetch_err
);

   localparam int                CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_ERR   = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_req;
   logic                    w_req_nxt;
   logic                    w_capture;
   logic                    w_accept;
   logic                    w_wait_inc;
   logic [PC_WIDTH-1:0]     r_pc;
   logic [INSTR_WIDTH-1:0]  r_instr;
   logic [PC_WIDTH-1:0]     r_instr_pc;
   logic [CNT_W-1:0]        r_wait_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_req   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
      end
   end

   // FETCH spends one idle cycle with the request low (after reset or after a
   // decode handshake) before raising it; this keeps imem_req a clean register
   // and gives the one-instruction-per-three-cycles cadence.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_wait_inc  = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (!r_req) begin
               w_req_nxt = 1'b1;
            end else if (imem_ack) begin
               // an ack on the last permitted cycle still beats the timeout
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end else if (r_wait_cnt == CNT_MAX) begin
               w_state_nxt = S_ERR;
            end else begin
               w_req_nxt  = 1'b1;
               w_wait_inc = 1'b1;
            end
         end
         S_HOLD: begin
            if (instr_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_ERR: begin
            w_state_nxt = S_ERR;
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_wait_cnt <= '0;
      end else begin
         if (w_capture) begin
            r_instr    <= imem_data;
            r_instr_pc <= r_pc;
            r_wait_cnt <= '0;
         end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         // next_pc is taken verbatim; any wrap is the next-PC logic's business
         if (w_accept) begin
            r_pc <= next_pc;
         end
      end
   end

   assign curr_pc     = r_pc;
   assign imem_addr   = r_pc;
   assign imem_req    = r_req;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = (r_state == S_HOLD);
   assign fetch_err   = (r_state == S_ERR);

endmodule
